iro_sequencer: RTL and testbench

- Sequences one instrumented ring oscillator instance (25 seed stages, 16 observed phases) for a measurement.
- Serially loads a 25-bit seed over the oscillator's bclk/bdat interface, then sets the tap select.
- Runs the ring for a programmed number of system clocks, counting rising edges of phase 0, then freezes it with hold.
- Captures the synchronised phase word and returns it with the edge count via a valid/ready result port.

---
 rtl/iro_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_iro_sequencer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/iro_sequencer.sv
// Sequencer for one instrumented ring oscillator: serial seed load, timed run with
// phase-0 edge counting, hold/settle, phase capture and a valid/ready result port.
module iro_sequencer #(
    parameter int N_STAGES = 25,
    parameter int BCLK_DIV = 2,
    parameter int SETTLE   = 4,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic                start_ready,
    input  logic [N_STAGES-1:0] cfg_seed,
    input  logic [3:0]          cfg_n_stages,
    input  logic [15:0]         cfg_run_len,
    input  logic                abort,
    output logic                iro_enable,
    output logic                iro_hold,
    output logic                iro_bclk,
    output logic                iro_bdat,
    output logic [3:0]          iro_n_stages,
    input  logic [15:0]         iro_phases,
    output logic                busy,
    output logic                result_valid,
    input  logic                result_ready,
    output logic [15:0]         result_phases,
    output logic [CNT_W-1:0]    result_edges,
    output logic                result_sat
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_RUN,
        S_HOLD,
        S_DONE
    } state_t;

    localparam int DIV_W = $clog2(2 * BCLK_DIV);
    localparam int BIT_W = $clog2(N_STAGES + 1);
    localparam logic [DIV_W-1:0] DIV_HI   = DIV_W'(BCLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * BCLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(N_STAGES);
    localparam logic [15:0]      SETTLE_V = 16'(SETTLE);
    localparam logic [CNT_W-1:0] EDGE_MAX = '1;

    state_t              state;
    state_t              state_nxt;
    logic [15:0]         ph_meta;
    logic [15:0]         ph_s;
    logic                ph_d;
    logic [N_STAGES-1:0] seed_q;
    logic [DIV_W-1:0]    div_cnt;
    logic [BIT_W-1:0]    bit_cnt;
    logic [15:0]         tmr;
    logic [15:0]         run_len_q;
    logic [CNT_W-1:0]    edge_cnt;
    logic                sat_q;
    logic [15:0]         phases_q;
    logic [3:0]          n_stages_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // bit_cnt == BIT_LAST is the trailing bclk-low cycle after the final bit
    always_comb begin
        state_nxt    = state;
        start_ready  = 1'b0;
        busy         = 1'b1;
        iro_enable   = 1'b0;
        iro_hold     = 1'b0;
        iro_bclk     = 1'b0;
        iro_bdat     = 1'b0;
        result_valid = 1'b0;
        case (state)
            S_IDLE: begin
                start_ready = 1'b1;
                busy        = 1'b0;
                if (start) begin
                    state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (bit_cnt == BIT_LAST) begin
                    state_nxt = S_RUN;
                end else begin
                    iro_bclk = (div_cnt >= DIV_HI);
                    iro_bdat = seed_q[N_STAGES-1];
                end
            end
            S_RUN: begin
                iro_enable = 1'b1;
                if (tmr == 16'd1) begin
                    state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                iro_enable = 1'b1;
                iro_hold   = 1'b1;
                if (tmr == 16'd1) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                result_valid = 1'b1;
                if (result_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (abort && (state != S_IDLE)) begin
            state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph_meta    <= '0;
            ph_s       <= '0;
            ph_d       <= 1'b0;
            seed_q     <= '0;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            tmr        <= '0;
            run_len_q  <= '0;
            edge_cnt   <= '0;
            sat_q      <= 1'b0;
            phases_q   <= '0;
            n_stages_q <= '0;
        end else begin
            ph_meta <= iro_phases;
            ph_s    <= ph_meta;
            ph_d    <= ph_s[0];
            case (state)
                S_IDLE: begin
                    if (start) begin
                        seed_q     <= cfg_seed;
                        n_stages_q <= cfg_n_stages;
                        run_len_q  <= cfg_run_len;
                        div_cnt    <= '0;
                        bit_cnt    <= '0;
                        edge_cnt   <= '0;
                        sat_q      <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    if (bit_cnt != BIT_LAST) begin
                        if (div_cnt == DIV_LAST) begin
                            div_cnt <= '0;
                            bit_cnt <= bit_cnt + 1'b1;
                            seed_q  <= {seed_q[N_STAGES-2:0], 1'b0};
                        end else begin
                            div_cnt <= div_cnt + 1'b1;
                        end
                    end else begin
                        tmr <= (run_len_q == 16'd0) ? 16'd1 : run_len_q;
                    end
                end
                S_RUN: begin
                    if (ph_s[0] && !ph_d) begin
                        if (edge_cnt == EDGE_MAX) begin
                            sat_q <= 1'b1;
                        end else begin
                            edge_cnt <= edge_cnt + 1'b1;
                        end
                    end
                    tmr <= (tmr == 16'd1) ? SETTLE_V : tmr - 1'b1;
                end
                S_HOLD: begin
                    if (tmr == 16'd1) begin
                        phases_q <= ph_s;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign iro_n_stages  = n_stages_q;
    assign result_phases = phases_q;
    assign result_edges  = edge_cnt;
    assign result_sat    = sat_q;

endmodule

// File: tb/tb_iro_sequencer.sv
// Directed bench for iro_sequencer with a behavioural oscillator driving iro_phases;
// a second instance with a 4-bit edge counter covers saturation.
module tb_iro_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [24:0] cfg_seed = '0;
    logic [3:0]  cfg_n_stages = '0;
    logic [15:0] cfg_run_len = '0;
    logic        abort = 1'b0;
    logic        result_ready = 1'b0;
    logic [15:0] iro_phases;

    logic        start_ready, iro_enable, iro_hold, iro_bclk, iro_bdat, busy;
    logic        result_valid, result_sat;
    logic [3:0]  iro_n_stages;
    logic [15:0] result_phases, result_edges;

    logic        s_start_ready, s_iro_enable, s_iro_hold, s_iro_bclk, s_iro_bdat, s_busy;
    logic        s_result_valid, s_result_sat;
    logic [3:0]  s_iro_n_stages;
    logic [15:0] s_result_phases;
    logic [3:0]  s_result_edges;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int acc_cyc = 0;

    // behavioural oscillator: all phases invert every ph_period clocks while running
    logic [15:0] ph_word = 16'hA5C3;
    int          ph_period = 7;
    int          ph_tick = 0;

    assign iro_phases = ph_word;

    iro_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_ready(start_ready),
        .cfg_seed(cfg_seed), .cfg_n_stages(cfg_n_stages), .cfg_run_len(cfg_run_len),
        .abort(abort), .iro_enable(iro_enable), .iro_hold(iro_hold),
        .iro_bclk(iro_bclk), .iro_bdat(iro_bdat), .iro_n_stages(iro_n_stages),
        .iro_phases(iro_phases), .busy(busy), .result_valid(result_valid),
        .result_ready(result_ready), .result_phases(result_phases),
        .result_edges(result_edges), .result_sat(result_sat)
    );

    iro_sequencer #(.CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .start_ready(s_start_ready),
        .cfg_seed(cfg_seed), .cfg_n_stages(cfg_n_stages), .cfg_run_len(cfg_run_len),
        .abort(abort), .iro_enable(s_iro_enable), .iro_hold(s_iro_hold),
        .iro_bclk(s_iro_bclk), .iro_bdat(s_iro_bdat), .iro_n_stages(s_iro_n_stages),
        .iro_phases(iro_phases), .busy(s_busy), .result_valid(s_result_valid),
        .result_ready(result_ready), .result_phases(s_result_phases),
        .result_edges(s_result_edges), .result_sat(s_result_sat)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (iro_enable && !iro_hold) begin
            if (ph_tick == ph_period - 1) begin
                ph_word <= ~ph_word;
                ph_tick <= 0;
            end else begin
                ph_tick <= ph_tick + 1;
            end
        end else begin
            ph_tick <= 0;
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // issues one command; returns at the negedge right after the accept edge
    task automatic apply_stimulus(input logic [24:0] seed, input logic [3:0] nst,
                                  input logic [15:0] run_len, input logic with_abort);
        @(negedge clk);
        cfg_seed     = seed;
        cfg_n_stages = nst;
        cfg_run_len  = run_len;
        start        = 1'b1;
        abort        = with_abort;
        @(posedge clk);
        @(negedge clk);
        start   = 1'b0;
        abort   = 1'b0;
        acc_cyc = cyc;
    endtask

    task automatic wait_valid(input int limit);
        for (int n = 0; n < limit && result_valid !== 1'b1; n++) @(negedge clk);
    endtask

    task automatic handshake();
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
    endtask

    initial begin
        logic [24:0] seed_v;
        logic        prev_bclk, prev_bdat;
        int          k, viol, lat;
        logic [15:0] edges0, phases0;

        #23;
        check_output("rst_start_ready", start_ready, 1'b1);
        check_output("rst_busy", busy, 1'b0);
        check_output("rst_outputs", {iro_enable, iro_hold, iro_bclk, iro_bdat, result_valid}, 5'b0);
        check_output("rst_edges", result_edges, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // seed load and measurement
        seed_v = 25'h1A5_5A5A;
        apply_stimulus(seed_v, 4'd9, 16'd700, 1'b0);
        check_output("acc_busy", busy, 1'b1);
        check_output("acc_n_stages", iro_n_stages, 4'd9);
        prev_bclk = 1'b0;
        prev_bdat = 1'b0;
        k = 0;
        viol = 0;
        for (int i = 0; i < 101; i++) begin
            if (i > 0) @(negedge clk);
            if (iro_bclk && !prev_bclk) begin
                if (k < 25) check_output($sformatf("bdat_bit%0d", 24 - k), iro_bdat, seed_v[24-k]);
                k++;
            end
            if (iro_bclk && (iro_bdat !== prev_bdat)) viol++;
            prev_bclk = iro_bclk;
            prev_bdat = iro_bdat;
        end
        check_output("bclk_rises", k, 25);
        check_output("bdat_stable", viol, 0);
        check_output("shift_tail_bclk", iro_bclk, 1'b0);
        @(negedge clk);
        check_output("run_enable", {iro_enable, iro_hold}, 2'b10);
        wait_valid(2000);
        lat = cyc - acc_cyc;
        check_output("meas_valid", result_valid, 1'b1);
        check_output("meas_latency", lat, 805);
        check_output("meas_edges_49_51", (result_edges >= 49 && result_edges <= 51), 1'b1);
        check_output("meas_sat", result_sat, 1'b0);
        check_output("meas_phases", result_phases, ph_word);
        check_output("done_outputs", {iro_enable, iro_hold, start_ready}, 3'b000);

        // result held while the consumer stalls; start ignored
        edges0  = result_edges;
        phases0 = result_phases;
        viol = 0;
        for (int i = 0; i < 20; i++) begin
            start = (i == 5);
            @(negedge clk);
            if (result_valid !== 1'b1 || result_edges !== edges0 ||
                result_phases !== phases0 || start_ready !== 1'b0) viol++;
        end
        start = 1'b0;
        check_output("hs_stall_stable", viol, 0);
        handshake();
        check_output("hs_valid_drop", result_valid, 1'b0);
        check_output("hs_start_ready", start_ready, 1'b1);

        // saturation of the 4-bit instance
        ph_period = 2;
        apply_stimulus(25'h0F0_F0F0, 4'd3, 16'd200, 1'b0);
        wait_valid(1000);
        lat = cyc - acc_cyc;
        check_output("sat_latency", lat, 305);
        check_output("sat_edges4", s_result_edges, 4'd15);
        check_output("sat_flag4", s_result_sat, 1'b1);
        check_output("sat_edges16_49_51", (result_edges >= 49 && result_edges <= 51), 1'b1);
        check_output("sat_flag16", result_sat, 1'b0);
        handshake();

        // abort at the start of bit 10
        apply_stimulus(25'h155_5555, 4'd5, 16'd50, 1'b0);
        repeat (40) @(negedge clk);
        check_output("abort_pre_busy", busy, 1'b1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_output("abort_idle", {busy, start_ready}, 2'b01);
        check_output("abort_outputs", {iro_bclk, iro_enable, iro_hold, result_valid}, 4'b0);
        viol = 0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (result_valid !== 1'b0 || iro_enable !== 1'b0) viol++;
        end
        check_output("abort_quiet", viol, 0);

        // asynchronous reset in the middle of RUN
        apply_stimulus(25'h0AB_CDEF, 4'd7, 16'd300, 1'b0);
        repeat (110) @(negedge clk);
        check_output("midrun_enable", iro_enable, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("async_rst_outputs",
                     {iro_enable, iro_hold, iro_bclk, iro_bdat, result_valid, busy}, 6'b0);
        check_output("async_rst_ready", start_ready, 1'b1);
        check_output("async_rst_nst", iro_n_stages, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // run_len of zero, started together with abort
        ph_period = 7;
        apply_stimulus(25'h1FF_FFFF, 4'd2, 16'd0, 1'b1);
        check_output("start_beats_abort", busy, 1'b1);
        repeat (101) @(negedge clk);
        check_output("rl0_run", {iro_enable, iro_hold}, 2'b10);
        @(negedge clk);
        check_output("rl0_hold", {iro_enable, iro_hold}, 2'b11);
        wait_valid(50);
        lat = cyc - acc_cyc;
        check_output("rl0_latency", lat, 106);
        check_output("rl0_enable_off", iro_enable, 1'b0);
        handshake();
        check_output("rl0_idle", start_ready, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
